obstacle_scheduler: RTL and testbench
=====================================

Name: obstacle_scheduler

Overview:
- Sequences the obstacle generators (mouse follower and siblings) during a game.
- Picks which obstacle runs next and drives the shared `selected` code plus a one-cycle `done_control` launch pulse.
- Waits for that obstacle's `done`, inserts a pause, then launches the next one.
- Sits between the menu/game-state logic and the parallel chain of obstacle modules.

Parameters:
- NUM_OBSTACLES, 5: number of obstacle generators. Legal range 4..8. Index i is driven on `selected` as binary value i.
- ROUNDS, 10: obstacles launched per game before the sequence is complete.
- GAP_CYCLES, 65000000: pause between obstacles, in pclk cycles (1 s at 65 MHz).
- TIMEOUT_CYCLES, 1300000000: watchdog limit while an obstacle runs (20 s at 65 MHz).

Ports:
- pclk  in  1  pixel clock; the only clock.
- rst  in  1  reset, asynchronous, active-low.
- game_on  in  1  game screen active.
- menu_on  in  1  menu screen active.
- play_selected  in  1  player has chosen "play".
- obstacle_done  in  NUM_OBSTACLES  per-obstacle completion pulse; bit i comes from obstacle i.
- selected  out  4  index of the current obstacle.
- done_control  out  1  one-cycle launch strobe to all obstacles.
- round_cnt  out  4  obstacles completed in this game.
- seq_done  out  1  all ROUNDS finished.
- timeout_err  out  1  sticky flag: a watchdog expiry occurred.

Behaviour:
- All outputs and state are registered. Reset is applied asynchronously on the falling edge of rst and released synchronously.
- Reset values: state IDLE, selected 0, done_control 0, round_cnt 0, seq_done 0, timeout_err 0, counters 0, prev index 0, LFSR 8'h01.
- States: IDLE, LAUNCH, RUN, GAP, FINISH.
- IDLE
  - Enter LAUNCH when game_on && play_selected && !menu_on.
  - On that transition, clear round_cnt, timeout_err and the watchdog.
- LAUNCH (exactly 1 cycle)
  - selected_nxt = next index; done_control_nxt = 1.
  - Go to RUN. The pulse and new `selected` appear together on the outputs one cycle after the LAUNCH decision.
  - done_control is high for exactly one cycle per launch and is 0 in every other state.
- RUN
  - The watchdog increments every cycle.
  - obstacle_done[selected] = 1: watchdog clears, round_cnt increments. If the new count equals ROUNDS go to FINISH, otherwise go to GAP.
  - Done bits from non-selected obstacles are ignored.
  - Watchdog reaches TIMEOUT_CYCLES-1 without done: set timeout_err, treat as completed (same round increment and routing).
  - Done and timeout in the same cycle: done wins and timeout_err is not set.
- GAP
  - Counter runs 0..GAP_CYCLES-1, then go to LAUNCH.
  - `selected` holds the last index during GAP.
- FINISH
  - seq_done = 1 and selected = 0; hold until abort.
- Abort
  - In any non-IDLE state, menu_on || !play_selected moves to IDLE on the next cycle.
  - selected -> 0, done_control -> 0, seq_done -> 0. round_cnt and timeout_err keep their values until the next start.
  - Abort has priority over done, timeout and gap expiry arriving in the same cycle.
- Next-index rule (default): first launch of a game uses 0, then (prev+1) wrapping at NUM_OBSTACLES.
- Width rules:
  - Watchdog is 31 bits; GAP counter is 26 bits.
  - round_cnt saturates at ROUNDS; ROUNDS ≤ 15.
  - Comparisons against parameters are unsigned.

Optional Feature:
- OBSTACLE_RANDOM_ORDER_EN defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) advances every pclk from reset.
  - Candidate index c = lfsr[2:0], minus NUM_OBSTACLES if c ≥ NUM_OBSTACLES.
  - If c equals the previous index, use (c+1) mod NUM_OBSTACLES. No obstacle ever runs twice in a row.
  - The first launch also uses this rule.
- Undefined: no LFSR is instantiated; the sequential rotation described above applies.

Decomposition:
- Shared package holds:
  - state encoding constants;
  - obstacle index codes, e.g. MOUSE_FOLLOWER = 4'd4, shared with each obstacle's `selected` comparison;
  - default timing constants in 65 MHz cycles.
- One natural sub-module: obstacle_lfsr (8-bit LFSR plus index reduction), instantiated only under OBSTACLE_RANDOM_ORDER_EN.

Test Plan (bench parameters: NUM_OBSTACLES=5, ROUNDS=3, GAP_CYCLES=4, TIMEOUT_CYCLES=20):
- Reset then start: rst low, then high; game_on=1, play_selected=1 -> done_control high for 1 cycle with selected=0; round_cnt=0.
- Normal sequence: pulse obstacle_done[selected] 5 cycles after each launch -> launches with selected 0,1,2, each 4 gap cycles apart; then seq_done=1 and round_cnt=3.
- Wrong done: pulse obstacle_done[3] while selected=1 -> stays in RUN; no round increment.
- Timeout: withhold done -> 20 cycles after launch timeout_err=1, round_cnt +1, next launch follows after the gap.
- Abort mid-RUN: menu_on=1 in the same cycle as obstacle_done[selected] -> next cycle IDLE, selected=0, round_cnt unchanged.
- Random order (macro defined): run 15 launches -> every selected value < 5 and no two consecutive launches are equal.

Source files
------------

// File: rtl/obstacle_scheduler_pkg.sv
// Shared definitions for the obstacle scheduler and the obstacle generators:
// FSM encoding, obstacle index codes, default 65 MHz timing and index helpers.
package obstacle_scheduler_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LAUNCH = 3'd1,
      ST_RUN    = 3'd2,
      ST_GAP    = 3'd3,
      ST_FINISH = 3'd4
   } state_t;

   // Codes on `selected`; each obstacle compares against its own code
   localparam logic [3:0] OBS_0          = 4'd0;
   localparam logic [3:0] OBS_1          = 4'd1;
   localparam logic [3:0] OBS_2          = 4'd2;
   localparam logic [3:0] OBS_3          = 4'd3;
   localparam logic [3:0] MOUSE_FOLLOWER = 4'd4;

   // Defaults at 65 MHz pclk
   localparam int unsigned DEF_NUM_OBSTACLES  = 5;
   localparam int unsigned DEF_ROUNDS         = 10;
   localparam int unsigned DEF_GAP_CYCLES     = 65_000_000;     // 1 s
   localparam int unsigned DEF_TIMEOUT_CYCLES = 1_300_000_000;  // 20 s

   // (idx+1) mod n; any idx >= n-1 wraps to 0
   function automatic logic [3:0] wrap_inc(input logic [3:0] idx, input logic [3:0] n);
      logic [4:0] w_inc;
      w_inc = {1'b0, idx} + 5'd1;
      return (w_inc >= {1'b0, n}) ? 4'd0 : w_inc[3:0];
   endfunction

endpackage

// File: rtl/obstacle_scheduler_if.sv
// Control/obstacle bus around the scheduler. master = scheduler side,
// slave = game-state logic plus the obstacle chain.
interface obstacle_scheduler_if
   import obstacle_scheduler_pkg::*;
#(
   parameter int unsigned NUM_OBSTACLES = DEF_NUM_OBSTACLES
);
   logic                     game_on;
   logic                     menu_on;
   logic                     play_selected;
   logic [NUM_OBSTACLES-1:0] obstacle_done;
   logic [3:0]               selected;
   logic                     done_control;
   logic [3:0]               round_cnt;
   logic                     seq_done;
   logic                     timeout_err;

   modport master (
      input  game_on, menu_on, play_selected, obstacle_done,
      output selected, done_control, round_cnt, seq_done, timeout_err
   );

   modport slave (
      output game_on, menu_on, play_selected, obstacle_done,
      input  selected, done_control, round_cnt, seq_done, timeout_err
   );
endinterface

// File: rtl/obstacle_lfsr.sv
// Random next-obstacle picker: free-running 8-bit Fibonacci LFSR
// (taps 8,6,5,4) reduced into 0..NUM_OBSTACLES-1, never repeating i_prev.
module obstacle_lfsr
   import obstacle_scheduler_pkg::*;
#(
   parameter int unsigned NUM_OBSTACLES = DEF_NUM_OBSTACLES
) (
   input  logic       pclk,
   input  logic       rst,
   input  logic [3:0] i_prev,
   output logic [3:0] o_idx
);
   localparam logic [3:0] N4 = 4'(NUM_OBSTACLES);

   logic [7:0] r_lfsr;
   logic       w_fb;
   logic [3:0] w_cand;

   assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

   // LFSR advances every cycle from reset
   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) r_lfsr <= 8'h01;
      else      r_lfsr <= {r_lfsr[6:0], w_fb};
   end

   // Fold 0..7 into range (one subtract suffices for N >= 4), then dodge the repeat
   always_comb begin
      w_cand = {1'b0, r_lfsr[2:0]};
      if (w_cand >= N4) w_cand = w_cand - N4;
      o_idx = (w_cand == i_prev) ? wrap_inc(w_cand, N4) : w_cand;
   end
endmodule

// File: rtl/obstacle_scheduler.sv
// Obstacle scheduler: launches one obstacle at a time, waits for its done
// (or a watchdog expiry), pauses GAP_CYCLES, repeats for ROUNDS launches.
// Build option: OBSTACLE_RANDOM_ORDER_EN selects LFSR order instead of rotation.
module obstacle_scheduler
   import obstacle_scheduler_pkg::*;
#(
   parameter int unsigned NUM_OBSTACLES  = DEF_NUM_OBSTACLES,
   parameter int unsigned ROUNDS         = DEF_ROUNDS,
   parameter int unsigned GAP_CYCLES     = DEF_GAP_CYCLES,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                  pclk,
   input  logic                  rst,
   obstacle_scheduler_if.master  bus
);
   localparam logic [3:0]  N4       = 4'(NUM_OBSTACLES);
   localparam logic [3:0]  ROUNDS_L = 4'(ROUNDS);
   localparam logic [25:0] GAP_LAST = 26'(GAP_CYCLES - 1);
   localparam logic [30:0] WD_LAST  = 31'(TIMEOUT_CYCLES - 1);

   state_t      r_state,       w_state_nxt;
   logic [3:0]  r_selected,    w_selected_nxt;
   logic        r_done_ctl,    w_done_ctl_nxt;
   logic [3:0]  r_round_cnt,   w_round_cnt_nxt;
   logic        r_seq_done,    w_seq_done_nxt;
   logic        r_timeout_err, w_timeout_err_nxt;
   logic [30:0] r_wdog,        w_wdog_nxt;
   logic [25:0] r_gap,         w_gap_nxt;
   logic [3:0]  r_prev,        w_prev_nxt;

   logic [3:0]  w_next_idx;
   logic [15:0] w_done_pad;
   logic        w_hit, w_tmo, w_abort, w_start;
   logic [3:0]  w_rc_inc;

`ifdef OBSTACLE_RANDOM_ORDER_EN
   obstacle_lfsr #(.NUM_OBSTACLES(NUM_OBSTACLES)) u_lfsr (
      .pclk   (pclk),
      .rst    (rst),
      .i_prev (r_prev),
      .o_idx  (w_next_idx)
   );
`else
   // round_cnt is 0 only before the first completion of a game
   assign w_next_idx = (r_round_cnt == 4'd0) ? 4'd0 : wrap_inc(r_prev, N4);
`endif

   // Pad so a 4-bit index is always in range; missing bits read as 0
   assign w_done_pad = 16'(bus.obstacle_done);
   assign w_hit      = w_done_pad[r_selected];
   assign w_tmo      = (r_wdog == WD_LAST);
   assign w_abort    = bus.menu_on || !bus.play_selected;
   assign w_start    = bus.game_on && bus.play_selected && !bus.menu_on;
   assign w_rc_inc   = (r_round_cnt < ROUNDS_L) ? r_round_cnt + 4'd1 : r_round_cnt;

   // Next-state and next-output logic; abort overrides everything at the end
   always_comb begin
      w_state_nxt       = r_state;
      w_selected_nxt    = r_selected;
      w_done_ctl_nxt    = 1'b0;
      w_round_cnt_nxt   = r_round_cnt;
      w_seq_done_nxt    = r_seq_done;
      w_timeout_err_nxt = r_timeout_err;
      w_wdog_nxt        = '0;
      w_gap_nxt         = '0;
      w_prev_nxt        = r_prev;
      case (r_state)
         ST_IDLE: begin
            if (w_start) begin
               w_state_nxt       = ST_LAUNCH;
               w_round_cnt_nxt   = 4'd0;
               w_timeout_err_nxt = 1'b0;
            end
         end
         ST_LAUNCH: begin
            w_selected_nxt = w_next_idx;
            w_prev_nxt     = w_next_idx;
            w_done_ctl_nxt = 1'b1;
            w_state_nxt    = ST_RUN;
         end
         ST_RUN: begin
            w_wdog_nxt = r_wdog + 31'd1;
            if (w_hit || w_tmo) begin
               w_wdog_nxt      = '0;
               w_round_cnt_nxt = w_rc_inc;
               // a done in the expiry cycle still counts as a clean finish
               if (!w_hit) w_timeout_err_nxt = 1'b1;
               if (w_rc_inc == ROUNDS_L) begin
                  w_state_nxt    = ST_FINISH;
                  w_seq_done_nxt = 1'b1;
                  w_selected_nxt = 4'd0;
               end else begin
                  w_state_nxt = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            w_gap_nxt = r_gap + 26'd1;
            if (r_gap == GAP_LAST) begin
               w_gap_nxt   = '0;
               w_state_nxt = ST_LAUNCH;
            end
         end
         ST_FINISH: begin
            w_seq_done_nxt = 1'b1;
            w_selected_nxt = 4'd0;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      if (r_state != ST_IDLE && w_abort) begin
         w_state_nxt       = ST_IDLE;
         w_selected_nxt    = 4'd0;
         w_done_ctl_nxt    = 1'b0;
         w_seq_done_nxt    = 1'b0;
         w_round_cnt_nxt   = r_round_cnt;
         w_timeout_err_nxt = r_timeout_err;
         w_wdog_nxt        = '0;
         w_gap_nxt         = '0;
      end
   end

   // State and output registers
   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         r_state       <= ST_IDLE;
         r_selected    <= 4'd0;
         r_done_ctl    <= 1'b0;
         r_round_cnt   <= 4'd0;
         r_seq_done    <= 1'b0;
         r_timeout_err <= 1'b0;
         r_wdog        <= '0;
         r_gap         <= '0;
         r_prev        <= 4'd0;
      end else begin
         r_state       <= w_state_nxt;
         r_selected    <= w_selected_nxt;
         r_done_ctl    <= w_done_ctl_nxt;
         r_round_cnt   <= w_round_cnt_nxt;
         r_seq_done    <= w_seq_done_nxt;
         r_timeout_err <= w_timeout_err_nxt;
         r_wdog        <= w_wdog_nxt;
         r_gap         <= w_gap_nxt;
         r_prev        <= w_prev_nxt;
      end
   end

   assign bus.selected     = r_selected;
   assign bus.done_control = r_done_ctl;
   assign bus.round_cnt    = r_round_cnt;
   assign bus.seq_done     = r_seq_done;
   assign bus.timeout_err  = r_timeout_err;
endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed bench for obstacle_scheduler (N=5, ROUNDS=3, GAP=4, TIMEOUT=20).
// Inputs are driven and outputs sampled on the falling pclk edge.
module tb_obstacle_scheduler;
   logic pclk = 1'b0;
   logic rst  = 1'b0;
   int   errors = 0;
   int   checks = 0;
   logic [3:0] sel;
   int         lat;

   always #5 pclk = ~pclk;

   obstacle_scheduler_if #(.NUM_OBSTACLES(5)) bus ();

   obstacle_scheduler #(
      .NUM_OBSTACLES  (5),
      .ROUNDS         (3),
      .GAP_CYCLES     (4),
      .TIMEOUT_CYCLES (20)
   ) u_dut (
      .pclk (pclk),
      .rst  (rst),
      .bus  (bus)
   );

   // Wait (bounded) for the launch strobe; lat = falling edges waited
   task automatic do_launch(output logic [3:0] s, output int l);
      l = 0;
      s = 4'd0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge pclk);
         if (bus.done_control === 1'b1) begin
            l = i;
            s = bus.selected;
            break;
         end
      end
      if (l == 0) begin
         errors++; checks++;
         $display("FAIL launch_wait: no done_control within 40 cycles");
      end
   endtask

   // One-cycle done pulse on obstacle idx; returns one falling edge later
   task automatic pulse_done(input int idx);
      logic [4:0] v;
      v = 5'd1 << idx;
      bus.obstacle_done = v;
      @(negedge pclk);
      bus.obstacle_done = '0;
   endtask

   task automatic test_reset();
      bus.game_on = 1'b0; bus.menu_on = 1'b0; bus.play_selected = 1'b0; bus.obstacle_done = '0;
      rst = 1'b0;
      repeat (3) @(negedge pclk);
      checks++; if (bus.selected !== 4'd0)    begin errors++; $display("FAIL rst_selected: got %0d want 0", bus.selected); end
      checks++; if (bus.done_control !== 1'b0) begin errors++; $display("FAIL rst_done_control: got %b want 0", bus.done_control); end
      checks++; if (bus.round_cnt !== 4'd0)   begin errors++; $display("FAIL rst_round_cnt: got %0d want 0", bus.round_cnt); end
      checks++; if (bus.seq_done !== 1'b0)    begin errors++; $display("FAIL rst_seq_done: got %b want 0", bus.seq_done); end
      checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout_err: got %b want 0", bus.timeout_err); end
      rst = 1'b1;
      @(negedge pclk);
   endtask

`ifdef OBSTACLE_RANDOM_ORDER_EN
   task automatic test_random_order();
      logic [3:0] prev;
      prev = 4'd0;
      bus.game_on = 1'b1; bus.play_selected = 1'b1;
      for (int k = 0; k < 15; k++) begin
         do_launch(sel, lat);
         checks++; if (sel >= 4'd5) begin errors++; $display("FAIL rnd_range: launch %0d got %0d want <5", k, sel); end
         if (k > 0) begin
            checks++; if (sel === prev) begin errors++; $display("FAIL rnd_repeat: launch %0d got %0d want != %0d", k, sel, prev); end
         end
         prev = sel;
         repeat (3) @(negedge pclk);
         pulse_done(int'(sel));
         if (bus.seq_done === 1'b1) begin
            bus.play_selected = 1'b0;
            @(negedge pclk);
            bus.play_selected = 1'b1;
         end
      end
   endtask
`else
   task automatic test_start();
      int seen;
      seen = 0;
      bus.game_on = 1'b1; bus.play_selected = 1'b0;
      repeat (4) begin @(negedge pclk); if (bus.done_control === 1'b1) seen++; end
      checks++; if (seen != 0) begin errors++; $display("FAIL idle_hold: got %0d launches want 0", seen); end
      bus.play_selected = 1'b1;
      do_launch(sel, lat);
      checks++; if (lat != 2)            begin errors++; $display("FAIL start_latency: got %0d want 2", lat); end
      checks++; if (sel !== 4'd0)        begin errors++; $display("FAIL start_selected: got %0d want 0", sel); end
      checks++; if (bus.round_cnt !== 4'd0) begin errors++; $display("FAIL start_round_cnt: got %0d want 0", bus.round_cnt); end
      @(negedge pclk);
      checks++; if (bus.done_control !== 1'b0) begin errors++; $display("FAIL pulse_width: got %b want 0", bus.done_control); end
   endtask

   task automatic test_normal();
      int seen;
      for (int r = 0; r < 3; r++) begin
         if (r > 0) begin
            do_launch(sel, lat);
            checks++; if (lat != 5)         begin errors++; $display("FAIL gap_latency: round %0d got %0d want 5", r, lat); end
            checks++; if (sel !== 4'(r))    begin errors++; $display("FAIL seq_selected: round %0d got %0d want %0d", r, sel, r); end
         end
         repeat ((r == 0) ? 3 : 4) @(negedge pclk);
         pulse_done(int'(sel));
         checks++; if (bus.round_cnt !== 4'(r + 1)) begin errors++; $display("FAIL seq_round_cnt: got %0d want %0d", bus.round_cnt, r + 1); end
      end
      checks++; if (bus.seq_done !== 1'b1) begin errors++; $display("FAIL finish_seq_done: got %b want 1", bus.seq_done); end
      checks++; if (bus.selected !== 4'd0) begin errors++; $display("FAIL finish_selected: got %0d want 0", bus.selected); end
      seen = 0;
      repeat (8) begin @(negedge pclk); if (bus.done_control === 1'b1) seen++; end
      checks++; if (seen != 0 || bus.seq_done !== 1'b1) begin errors++; $display("FAIL finish_hold: got launches=%0d seq_done=%b want 0/1", seen, bus.seq_done); end
      bus.play_selected = 1'b0;
      @(negedge pclk);
      checks++; if (bus.seq_done !== 1'b0)  begin errors++; $display("FAIL exit_seq_done: got %b want 0", bus.seq_done); end
      checks++; if (bus.round_cnt !== 4'd3) begin errors++; $display("FAIL exit_round_cnt: got %0d want 3", bus.round_cnt); end
   endtask

   task automatic test_wrong_done();
      bus.play_selected = 1'b1;
      do_launch(sel, lat);
      checks++; if (lat != 2 || bus.round_cnt !== 4'd0) begin errors++; $display("FAIL restart: got lat=%0d round_cnt=%0d want 2/0", lat, bus.round_cnt); end
      repeat (4) @(negedge pclk);
      pulse_done(0);
      do_launch(sel, lat);
      checks++; if (sel !== 4'd1) begin errors++; $display("FAIL wd_selected: got %0d want 1", sel); end
      @(negedge pclk);
      pulse_done(3);
      @(negedge pclk);
      checks++; if (bus.round_cnt !== 4'd1) begin errors++; $display("FAIL wd_round_cnt: got %0d want 1", bus.round_cnt); end
      checks++; if (bus.selected !== 4'd1)  begin errors++; $display("FAIL wd_hold_selected: got %0d want 1", bus.selected); end
      pulse_done(1);
      checks++; if (bus.round_cnt !== 4'd2) begin errors++; $display("FAIL wd_right_done: got %0d want 2", bus.round_cnt); end
   endtask

   task automatic test_abort();
      do_launch(sel, lat);
      checks++; if (lat != 5 || sel !== 4'd2) begin errors++; $display("FAIL ab_launch: got lat=%0d sel=%0d want 5/2", lat, sel); end
      repeat (2) @(negedge pclk);
      bus.menu_on = 1'b1; bus.obstacle_done = 5'b00100;
      @(negedge pclk);
      bus.menu_on = 1'b0; bus.obstacle_done = '0;
      checks++; if (bus.selected !== 4'd0)  begin errors++; $display("FAIL ab_selected: got %0d want 0", bus.selected); end
      checks++; if (bus.round_cnt !== 4'd2) begin errors++; $display("FAIL ab_round_cnt: got %0d want 2", bus.round_cnt); end
      do_launch(sel, lat);
      checks++; if (lat != 2 || sel !== 4'd0) begin errors++; $display("FAIL ab_relaunch: got lat=%0d sel=%0d want 2/0", lat, sel); end
   endtask

   task automatic test_timeout();
      repeat (19) @(negedge pclk);
      checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL to_early: got %b want 0", bus.timeout_err); end
      @(negedge pclk);
      checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL to_flag: got %b want 1", bus.timeout_err); end
      checks++; if (bus.round_cnt !== 4'd1)   begin errors++; $display("FAIL to_round_cnt: got %0d want 1", bus.round_cnt); end
      do_launch(sel, lat);
      checks++; if (lat != 5 || sel !== 4'd1) begin errors++; $display("FAIL to_next: got lat=%0d sel=%0d want 5/1", lat, sel); end
      bus.play_selected = 1'b0;
      @(negedge pclk);
      checks++; if (bus.timeout_err !== 1'b1 || bus.round_cnt !== 4'd1) begin errors++; $display("FAIL to_sticky: got err=%b rc=%0d want 1/1", bus.timeout_err, bus.round_cnt); end
      bus.play_selected = 1'b1;
      do_launch(sel, lat);
      checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear: got %b want 0", bus.timeout_err); end
   endtask

   task automatic test_done_vs_timeout();
      repeat (19) @(negedge pclk);
      pulse_done(0);
      checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL dvt_flag: got %b want 0", bus.timeout_err); end
      checks++; if (bus.round_cnt !== 4'd1)   begin errors++; $display("FAIL dvt_round_cnt: got %0d want 1", bus.round_cnt); end
      do_launch(sel, lat);
      checks++; if (lat != 5 || sel !== 4'd1) begin errors++; $display("FAIL dvt_next: got lat=%0d sel=%0d want 5/1", lat, sel); end
   endtask
`endif

   initial begin
      test_reset();
`ifdef OBSTACLE_RANDOM_ORDER_EN
      test_random_order();
`else
      test_start();
      test_normal();
      test_wrong_done();
      test_abort();
      test_timeout();
      test_done_vs_timeout();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
